fb_color_reader: RTL

- Reads one captured 176x144 RGB111 frame out of the frame buffer once the camera writer flags it as complete.
- Scans the frame linearly and counts the pure-red, pure-green and pure-blue pixels.
- Decides the dominant colour and holds the result for the car controller until it acknowledges.
- Sits on the buffer's read port, opposite the camera-side writer.

---
 rtl/fb_color_if.sv | 29 ++
 rtl/fb_color_reader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fb_color_if.sv
// Frame-buffer read port plus result handshake between the colour reader
// and its surroundings (frame buffer, camera writer flag, car controller).
interface fb_color_if #(
    parameter int AW = 15
);
    logic          frame_ready;
    logic [2:0]    rd_data;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic          busy;
    logic          done;
    logic          result_ack;
    logic [1:0]    color;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_g;
    logic [AW-1:0] cnt_b;

    // Reader side: drives the buffer address and the result.
    modport master (
        input  frame_ready, rd_data, result_ack,
        output rd_addr, rd_en, busy, done, color, cnt_r, cnt_g, cnt_b
    );

    // Environment side: buffer data, frame flag and consumer acknowledge.
    modport slave (
        output frame_ready, rd_data, result_ack,
        input  rd_addr, rd_en, busy, done, color, cnt_r, cnt_g, cnt_b
    );
endinterface

// File: rtl/fb_color_reader.sv
// Scans one RGB111 frame out of the frame buffer, counts pure red, green and
// blue pixels and reports the dominant colour until the consumer acknowledges.
//
// state  | meaning
// IDLE   | waiting for a rising edge of frame_ready
// SCAN   | issuing read addresses 0..NPIX-1
// DRAIN  | last read data in flight, accumulate it
// DECIDE | latch counts and pick the dominant colour
// HOLD   | result valid (done=1) until result_ack
module fb_color_reader #(
    parameter int AW     = 15,
    parameter int NPIX   = 25344,
    parameter int THRESH = 2000
) (
    input  logic       clk,
    input  logic       rst,
    fb_color_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_DECIDE, S_HOLD} state_t;

    localparam logic [AW-1:0] LAST     = AW'(NPIX - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [AW:0]   THRESH_W = (AW+1)'(THRESH);

    state_t        state_q, state_d;
    logic          fr_prev_q;
    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_en_q, rd_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [1:0]    color_q, color_d;
    logic [AW-1:0] acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
    logic [AW-1:0] cnt_r_q, cnt_r_d, cnt_g_q, cnt_g_d, cnt_b_q, cnt_b_d;
    logic          start;
    logic [AW-1:0] max_cnt;
    logic [1:0]    max_sel;

    assign start = bus.frame_ready && !fr_prev_q;

    // Largest accumulator; ties resolve red over green over blue.
    always_comb begin
        max_sel = 2'd1;
        max_cnt = acc_r_q;
        if (acc_r_q >= acc_g_q && acc_r_q >= acc_b_q) begin
            max_sel = 2'd1;
            max_cnt = acc_r_q;
        end else if (acc_g_q >= acc_b_q) begin
            max_sel = 2'd2;
            max_cnt = acc_g_q;
        end else begin
            max_sel = 2'd3;
            max_cnt = acc_b_q;
        end
    end

    // Next-state, address generation, pixel classification and result latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_en_d = rd_en_q;
        valid_d = rd_en_q;
        color_d = color_q;
        acc_r_d = acc_r_q;
        acc_g_d = acc_g_q;
        acc_b_d = acc_b_q;
        cnt_r_d = cnt_r_q;
        cnt_g_d = cnt_g_q;
        cnt_b_d = cnt_b_q;

        // Read data is one cycle behind rd_en; only pure primaries count.
        if (valid_q) begin
            case (bus.rd_data)
                3'b100:  acc_r_d = acc_r_q + ONE;
                3'b010:  acc_g_d = acc_g_q + ONE;
                3'b001:  acc_b_d = acc_b_q + ONE;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    addr_d  = '0;
                    rd_en_d = 1'b1;
                    acc_r_d = '0;
                    acc_g_d = '0;
                    acc_b_d = '0;
                end
            end
            S_SCAN: begin
                if (addr_q == LAST) begin
                    state_d = S_DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    addr_d = addr_q + ONE;
                end
            end
            S_DRAIN: state_d = S_DECIDE;
            S_DECIDE: begin
                cnt_r_d = acc_r_q;
                cnt_g_d = acc_g_q;
                cnt_b_d = acc_b_q;
                color_d = ({1'b0, max_cnt} > THRESH_W) ? max_sel : 2'd0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (bus.result_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_SCAN) || (state_d == S_DRAIN) || (state_d == S_DECIDE);
        done_d = (state_d == S_HOLD);
    end

    // All state and registered outputs; reset aborts any scan or held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            fr_prev_q <= 1'b0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            color_q   <= 2'd0;
            acc_r_q   <= '0;
            acc_g_q   <= '0;
            acc_b_q   <= '0;
            cnt_r_q   <= '0;
            cnt_g_q   <= '0;
            cnt_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            fr_prev_q <= bus.frame_ready;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            color_q   <= color_d;
            acc_r_q   <= acc_r_d;
            acc_g_q   <= acc_g_d;
            acc_b_q   <= acc_b_d;
            cnt_r_q   <= cnt_r_d;
            cnt_g_q   <= cnt_g_d;
            cnt_b_q   <= cnt_b_d;
        end
    end

    assign bus.rd_addr = addr_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.color   = color_q;
    assign bus.cnt_r   = cnt_r_q;
    assign bus.cnt_g   = cnt_g_q;
    assign bus.cnt_b   = cnt_b_q;
endmodule
